sonar_array: RTL and testbench
==============================

// Module: sonar_array
// PURPOSE
//  N-channel ultrasonic ranger controller, successor of the fixed 3-sonar front end of roberto.
//  Fires each enabled HC-SR04 in round-robin with a guard gap. Times its echo and converts the width to cm.
//  Publishes per-channel distance and valid flags, then pulses pronto once per sweep.
//  Sits between the sonar pins and the servo/serial logic.
// PARAMETERS
//  N_CH        3        number of sonar channels (1..8)
//  DIST_W      9        distance width per channel, cm, binary
//  CM_CYCLES   2940     clock cycles per cm of range (58.8 us at 50 MHz)
//  TRIG_CYCLES 500      trigger pulse width (10 us)
//  ECHO_WAIT   1500000  max cycles from trigger fall to echo rise (30 ms)
//  MAX_CM      400      saturation distance; longer echo => invalid
//  GAP_CYCLES  3000000  guard time between channels (60 ms)
// PORTS
//  clock       in   1             system clock, 50 MHz
//  reset       in   1             asynchronous, active-low reset
//  medir       in   1             start sweep (level or pulse, sampled in IDLE)
//  continuo    in   1             1: restart sweep automatically after DONE
//  habilita    in   N_CH          per-channel enable mask, sampled at sweep start
//  echo        in   N_CH          sonar echo inputs (asynchronous)
//  trigger     out  N_CH          sonar trigger outputs
//  distancia   out  N_CH*DIST_W   channel k at [k*DIST_W +: DIST_W]
//  valido      out  N_CH          1: last measurement of channel k in range
//  pronto      out  1             1-cycle pulse at end of each sweep
//  ocupado     out  1             high from sweep start until DONE
//  db_estado   out  4             FSM state code, for debug
// BEHAVIOUR
//  Reset: trigger=0, distancia=0, valido=0, pronto=0, ocupado=0, FSM=IDLE, channel index=0.
//  Echo passes a 2-FF synchronizer, giving a fixed 2-cycle delay on both edges, so width is preserved.
//  FSM: IDLE -> (medir) LOAD -> SELECT -> TRIG -> WAIT_ECHO -> MEASURE -> STORE -> GAP -> SELECT ... -> DONE.
//   LOAD: latch habilita into mask; idx=0; ocupado=1.
//   SELECT: advance idx to the next set mask bit, starting at idx. If none remains -> DONE.
//   TRIG: trigger[idx]=1 for exactly TRIG_CYCLES cycles; other triggers stay 0.
//   WAIT_ECHO: on echo rise -> MEASURE. After ECHO_WAIT cycles with no rise -> STORE with timeout set.
//   MEASURE: subcounter counts cycles while echo is high; at CM_CYCLES-1 it wraps and cm++.
//     cm saturates at MAX_CM. Echo fall -> STORE. If cm reaches MAX_CM and echo is still high -> STORE with overrange.
//   STORE: distancia[idx]=cm, valido[idx]=!(timeout|overrange). On timeout distancia[idx] is set to MAX_CM.
//   GAP: wait GAP_CYCLES, skipped after the last enabled channel; then idx++ -> SELECT.
//   DONE: pronto=1 for 1 cycle, ocupado=0. If continuo=1 -> LOAD next cycle, else -> IDLE.
//  medir during a sweep is ignored. An habilita change takes effect on the next sweep.
//  Disabled channels: never triggered; distancia/valido hold their last values.
//  All channels disabled: medir -> pronto pulses 2 cycles after LOAD, with no trigger activity.
//  Echo already high on entering WAIT_ECHO (stuck sensor): treated as no rise; wait for a 0->1 edge.
//  Arithmetic: cm = floor(echo_cycles / CM_CYCLES), truncated, unless rounding is compiled in.
//  distancia updates only in STORE; the other channels' outputs are stable during a sweep.
//  Reset mid-sweep: immediate return to reset values. Any trigger in progress drops asynchronously.
// CONFIGURATION
//  SONAR_ROUND_EN defined: the subcounter preloads CM_CYCLES/2 at echo rise.
//   Result is cm = floor((cycles + CM_CYCLES/2) / CM_CYCLES), i.e. rounded to nearest.
//  SONAR_ROUND_EN undefined: the subcounter preloads 0, giving truncation. No other differences.
// STRUCTURE
//  sonar_pkg: state enum with db_estado codes, clog2-based widths for idx and counters,
//   default timing constants.
//  Sub-module sonar_echo_timer: synchronizer, edge detect, subcounter/cm counter, saturation.
//   It is instanced once; echo[idx] is muxed in.
//  Top holds the FSM, mask, trigger timer, gap timer and output registers.
// TESTING
//  T1: N_CH=3, all enabled, echo 1180 us on ch0..2 -> distancia=20 on each, valido=3'b111, one pronto.
//  T2: echo 600 us -> 10. Echo 4399 us -> 74 without SONAR_ROUND_EN, 75 with it.
//  T3: habilita=3'b101 -> trigger[1] never rises. Triggers fire in order ch0 then ch2, separated by >= GAP_CYCLES.
//  T4: ch1 never echoes -> after ECHO_WAIT, valido[1]=0 and distancia[1]=400; ch0/ch2 still valid.
//  T5: echo 25 ms -> saturates at 400, valido=0. Habilita=0 -> pronto with no trigger pulse.
//  T6: continuo=1 -> back-to-back pronto per sweep. Reset asserted mid-TRIG -> trigger=0 and all outputs 0.
//   Medir pulses during a sweep produce no extra sweep.

Source files
------------

// File: rtl/sonar_pkg.sv
// ============================================================================
//  Module      : sonar_pkg
//  Description : Shared types and constants for the sonar_array ranger:
//                FSM state enum (its codes drive db_estado), default timing
//                constants and width helpers for index and timer counters.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package sonar_pkg;

    // FSM states; the encoding is exported on db_estado for debug
    typedef enum logic [3:0] {
        ST_IDLE      = 4'd0,
        ST_LOAD      = 4'd1,
        ST_SELECT    = 4'd2,
        ST_TRIG      = 4'd3,
        ST_WAIT_ECHO = 4'd4,
        ST_MEASURE   = 4'd5,
        ST_STORE     = 4'd6,
        ST_GAP       = 4'd7,
        ST_DONE      = 4'd8
    } state_t;

    // Default timing for a 50 MHz clock and HC-SR04 sensors
    localparam int c_def_n_ch        = 3;
    localparam int c_def_dist_w      = 9;
    localparam int c_def_cm_cycles   = 2940;
    localparam int c_def_trig_cycles = 500;
    localparam int c_def_echo_wait   = 1500000;
    localparam int c_def_max_cm      = 400;
    localparam int c_def_gap_cycles  = 3000000;

    // Width of a channel index; never below one bit
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // Width of a shared down-time counter able to reach the largest interval
    function automatic int cnt_width(input int a, input int b, input int c);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        return $clog2(m + 1);
    endfunction

endpackage : sonar_pkg

`default_nettype wire

// File: rtl/sonar_echo_timer.sv
// ============================================================================
//  Module      : sonar_echo_timer
//  Description : Echo path for the currently selected sonar channel:
//                2-FF synchronizer, rising-edge detect, sub-cycle counter
//                and saturating centimetre counter.
//                Optional feature macro: SONAR_ROUND_EN (round to nearest cm
//                by preloading half a centimetre at echo rise).
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module sonar_echo_timer #(
    parameter int CM_CYCLES = 2940,
    parameter int MAX_CM    = 400,
    parameter int DIST_W    = 9
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              echo_i,   // raw, asynchronous echo of selected channel
    input  logic              arm_i,    // waiting for the echo rise
    input  logic              run_i,    // measuring the echo width
    output logic              echo_o,   // synchronized echo level
    output logic              rise_o,   // synchronized 0->1 edge
    output logic              sat_o,    // centimetre count is at MAX_CM
    output logic [DIST_W-1:0] cm_o
);

    localparam int c_sub_w = (CM_CYCLES > 1) ? $clog2(CM_CYCLES) : 1;

`ifdef SONAR_ROUND_EN
    localparam int c_pre_int = CM_CYCLES / 2;
`else
    localparam int c_pre_int = 0;
`endif

    localparam logic [c_sub_w-1:0] c_pre      = c_sub_w'(c_pre_int);
    localparam logic [c_sub_w-1:0] c_sub_last = c_sub_w'(CM_CYCLES - 1);
    localparam logic [DIST_W-1:0]  c_max      = DIST_W'(MAX_CM);

    logic               sync1_q, sync2_q, prev_q;
    logic [c_sub_w-1:0] sub_q, sub_d, w_base_sub;
    logic [DIST_W-1:0]  cm_q, cm_d, w_base_cm;
    logic               w_rise, w_sat, w_step;

    assign w_rise = sync2_q & ~prev_q;
    assign w_sat  = (cm_q == c_max);

    // Synchronize the echo and keep one cycle of history for edge detection
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            prev_q  <= 1'b0;
        end else begin
            sync1_q <= echo_i;
            sync2_q <= sync1_q;
            prev_q  <= sync2_q;
        end
    end

    // One step per high echo cycle; the rise cycle restarts from the preload
    always_comb begin
        w_base_sub = arm_i ? c_pre : sub_q;
        w_base_cm  = arm_i ? '0    : cm_q;
        w_step     = (arm_i & w_rise) | (run_i & sync2_q & ~w_sat);
        sub_d      = sub_q;
        cm_d       = cm_q;
        if (w_step) begin
            if (w_base_sub == c_sub_last) begin
                sub_d = '0;
                cm_d  = w_base_cm + DIST_W'(1);
            end else begin
                sub_d = w_base_sub + c_sub_w'(1);
                cm_d  = w_base_cm;
            end
        end
    end

    // Counter registers
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sub_q <= '0;
            cm_q  <= '0;
        end else begin
            sub_q <= sub_d;
            cm_q  <= cm_d;
        end
    end

    assign echo_o = sync2_q;
    assign rise_o = w_rise;
    assign sat_o  = w_sat;
    assign cm_o   = cm_q;

endmodule : sonar_echo_timer

`default_nettype wire

// File: rtl/sonar_array.sv
// ============================================================================
//  Module      : sonar_array
//  Description : N-channel HC-SR04 ranger controller. Fires each enabled
//                sonar in round-robin with a guard gap, times its echo in
//                centimetres and publishes per-channel distance/valid flags,
//                pulsing pronto once per sweep.
//                Optional feature macro: SONAR_ROUND_EN (rounded cm result).
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module sonar_array
    import sonar_pkg::*;
#(
    parameter int N_CH        = c_def_n_ch,
    parameter int DIST_W      = c_def_dist_w,
    parameter int CM_CYCLES   = c_def_cm_cycles,
    parameter int TRIG_CYCLES = c_def_trig_cycles,
    parameter int ECHO_WAIT   = c_def_echo_wait,
    parameter int MAX_CM      = c_def_max_cm,
    parameter int GAP_CYCLES  = c_def_gap_cycles
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     medir_i,
    input  logic                     continuo_i,
    input  logic [N_CH-1:0]          habilita_i,
    input  logic [N_CH-1:0]          echo_i,
    output logic [N_CH-1:0]          trigger_o,
    output logic [N_CH*DIST_W-1:0]   distancia_o,
    output logic [N_CH-1:0]          valido_o,
    output logic                     pronto_o,
    output logic                     ocupado_o,
    output logic [3:0]               db_estado_o
);

    localparam int c_idx_w = idx_width(N_CH);
    localparam int c_tmr_w = cnt_width(TRIG_CYCLES, ECHO_WAIT, GAP_CYCLES);

    localparam logic [c_tmr_w-1:0] c_trig_last = c_tmr_w'(TRIG_CYCLES - 1);
    localparam logic [c_tmr_w-1:0] c_wait_last = c_tmr_w'(ECHO_WAIT - 1);
    localparam logic [c_tmr_w-1:0] c_gap_last  = c_tmr_w'(GAP_CYCLES - 1);
    localparam logic [DIST_W-1:0]  c_max       = DIST_W'(MAX_CM);

    state_t                   state_q, state_d;
    logic [c_idx_w-1:0]       idx_q, idx_d;
    logic [N_CH-1:0]          mask_q, mask_d;
    logic [c_tmr_w-1:0]       tmr_q, tmr_d;
    logic                     timeout_q, timeout_d;
    logic                     ovr_q, ovr_d;
    logic [N_CH*DIST_W-1:0]   dist_q, dist_d;
    logic [N_CH-1:0]          valid_q, valid_d;

    logic                     w_echo_sel, w_echo_s, w_rise, w_sat;
    logic [DIST_W-1:0]        w_cm;
    logic                     w_found, w_more;
    logic [c_idx_w-1:0]       w_next;

    // The single echo timer follows whichever channel is selected
    assign w_echo_sel = echo_i[idx_q];

    sonar_echo_timer #(
        .CM_CYCLES (CM_CYCLES),
        .MAX_CM    (MAX_CM),
        .DIST_W    (DIST_W)
    ) u_timer (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .echo_i (w_echo_sel),
        .arm_i  (state_q == ST_WAIT_ECHO),
        .run_i  (state_q == ST_MEASURE),
        .echo_o (w_echo_s),
        .rise_o (w_rise),
        .sat_o  (w_sat),
        .cm_o   (w_cm)
    );

    // Lowest enabled channel at or above idx, and whether any lies beyond idx
    always_comb begin
        w_found = 1'b0;
        w_more  = 1'b0;
        w_next  = '0;
        for (int i = N_CH - 1; i >= 0; i--) begin
            if (mask_q[i] && (i >= int'(idx_q))) begin
                w_found = 1'b1;
                w_next  = c_idx_w'(i);
            end
            if (mask_q[i] && (i > int'(idx_q))) begin
                w_more = 1'b1;
            end
        end
    end

    // Sweep sequencing: next state, shared interval timer and result capture
    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        mask_d    = mask_q;
        tmr_d     = tmr_q + c_tmr_w'(1);
        timeout_d = timeout_q;
        ovr_d     = ovr_q;
        dist_d    = dist_q;
        valid_d   = valid_q;
        case (state_q)
            ST_IDLE: begin
                tmr_d = '0;
                if (medir_i) state_d = ST_LOAD;
            end
            ST_LOAD: begin
                tmr_d   = '0;
                mask_d  = habilita_i;
                idx_d   = '0;
                state_d = ST_SELECT;
            end
            ST_SELECT: begin
                tmr_d     = '0;
                timeout_d = 1'b0;
                ovr_d     = 1'b0;
                if (w_found) begin
                    idx_d   = w_next;
                    state_d = ST_TRIG;
                end else begin
                    state_d = ST_DONE;
                end
            end
            ST_TRIG: begin
                if (tmr_q == c_trig_last) begin
                    tmr_d   = '0;
                    state_d = ST_WAIT_ECHO;
                end
            end
            ST_WAIT_ECHO: begin
                // A level already high here never produces a rise, so a
                // stuck sensor ends in the timeout branch.
                if (w_rise) begin
                    tmr_d   = '0;
                    state_d = ST_MEASURE;
                end else if (tmr_q == c_wait_last) begin
                    tmr_d     = '0;
                    timeout_d = 1'b1;
                    state_d   = ST_STORE;
                end
            end
            ST_MEASURE: begin
                tmr_d = '0;
                if (!w_echo_s) begin
                    state_d = ST_STORE;
                end else if (w_sat) begin
                    ovr_d   = 1'b1;
                    state_d = ST_STORE;
                end
            end
            ST_STORE: begin
                tmr_d = '0;
                dist_d[idx_q*DIST_W +: DIST_W] = timeout_q ? c_max : w_cm;
                valid_d[idx_q]                 = ~(timeout_q | ovr_q);
                state_d = w_more ? ST_GAP : ST_DONE;
            end
            ST_GAP: begin
                if (tmr_q == c_gap_last) begin
                    tmr_d   = '0;
                    idx_d   = idx_q + c_idx_w'(1);
                    state_d = ST_SELECT;
                end
            end
            ST_DONE: begin
                tmr_d   = '0;
                state_d = continuo_i ? ST_LOAD : ST_IDLE;
            end
            default: begin
                tmr_d   = '0;
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and result registers; reset clears everything immediately
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= ST_IDLE;
            idx_q     <= '0;
            mask_q    <= '0;
            tmr_q     <= '0;
            timeout_q <= 1'b0;
            ovr_q     <= 1'b0;
            dist_q    <= '0;
            valid_q   <= '0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            mask_q    <= mask_d;
            tmr_q     <= tmr_d;
            timeout_q <= timeout_d;
            ovr_q     <= ovr_d;
            dist_q    <= dist_d;
            valid_q   <= valid_d;
        end
    end

    // Trigger decoded from registered state so reset drops it at once
    always_comb begin
        trigger_o = '0;
        if (state_q == ST_TRIG) trigger_o[idx_q] = 1'b1;
    end

    assign distancia_o = dist_q;
    assign valido_o    = valid_q;
    assign pronto_o    = (state_q == ST_DONE);
    assign ocupado_o   = (state_q != ST_IDLE) && (state_q != ST_DONE);
    assign db_estado_o = state_q;

endmodule : sonar_array

`default_nettype wire

// File: tb/tb_sonar_array.sv
// ============================================================================
//  Module      : tb_sonar_array
//  Description : Self-checking bench for sonar_array with scaled timing.
//                Echo widths are randomized; expected distances come from
//                cm = floor((cycles + preload) / CM_CYCLES) with saturation.
//                Honours SONAR_ROUND_EN for the expected preload.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_sonar_array;

    localparam int N_CH   = 3;
    localparam int DIST_W = 9;
    localparam int CM     = 20;
    localparam int TRIG   = 5;
    localparam int EWAIT  = 300;
    localparam int MAXCM  = 30;
    localparam int GAP    = 60;
`ifdef SONAR_ROUND_EN
    localparam int PRE    = CM / 2;
`else
    localparam int PRE    = 0;
`endif
    // Longest echo that still yields a valid reading
    localparam int KSAT   = MAXCM * CM - PRE;

    logic                   clk = 1'b0;
    logic                   rst_n;
    logic                   medir, continuo;
    logic [N_CH-1:0]        habilita, echo;
    logic [N_CH-1:0]        trigger_o, valido_o;
    logic [N_CH*DIST_W-1:0] distancia_o;
    logic                   pronto_o, ocupado_o;
    logic [3:0]             db_estado_o;

    sonar_array #(
        .N_CH(N_CH), .DIST_W(DIST_W), .CM_CYCLES(CM), .TRIG_CYCLES(TRIG),
        .ECHO_WAIT(EWAIT), .MAX_CM(MAXCM), .GAP_CYCLES(GAP)
    ) dut (
        .clk_i(clk), .rst_ni(rst_n), .medir_i(medir), .continuo_i(continuo),
        .habilita_i(habilita), .echo_i(echo), .trigger_o(trigger_o),
        .distancia_o(distancia_o), .valido_o(valido_o), .pronto_o(pronto_o),
        .ocupado_o(ocupado_o), .db_estado_o(db_estado_o)
    );

    always #5 clk = ~clk;

    int n_pass = 0;
    int n_total = 0;
    int n_fail = 0;

    // Passive monitor: cycle count, pronto pulses, trigger rising edges
    int              cyc = 0;
    int              pronto_cnt = 0;
    int              rise_cnt [N_CH];
    logic [N_CH-1:0] trig_prev = '0;
    initial for (int k = 0; k < N_CH; k++) rise_cnt[k] = 0;
    always @(negedge clk) begin
        cyc = cyc + 1;
        if (pronto_o) pronto_cnt = pronto_cnt + 1;
        for (int k = 0; k < N_CH; k++)
            if (trigger_o[k] && !trig_prev[k]) rise_cnt[k] = rise_cnt[k] + 1;
        trig_prev = trigger_o;
    end

    // Reference state and per-channel echo scenario
    int m_dist [N_CH];
    bit m_val  [N_CH];
    int cfg_w  [N_CH];   // echo width in cycles
    int cfg_d  [N_CH];   // delay from trigger fall to echo rise
    int cfg_m  [N_CH];   // 0 normal, 1 silent, 2 stuck high, 3 stuck then real echo

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0d, required %0d", tag, obs, exp);
        end
    endtask

    task automatic model_update(input int k);
        if (cfg_m[k] == 1 || cfg_m[k] == 2) begin
            m_dist[k] = MAXCM; m_val[k] = 1'b0;
        end else if (cfg_w[k] > KSAT) begin
            m_dist[k] = MAXCM; m_val[k] = 1'b0;
        end else begin
            m_dist[k] = (cfg_w[k] + PRE) / CM; m_val[k] = 1'b1;
        end
    endtask

    task automatic cfg_rand();
        for (int k = 0; k < N_CH; k++) begin
            cfg_m[k] = 0;
            cfg_w[k] = $urandom_range(KSAT - 20, 1);
            cfg_d[k] = $urandom_range(40, 1);
        end
    endtask

    task automatic drive_echo(input int k);
        case (cfg_m[k])
            0: begin
                repeat (cfg_d[k]) @(negedge clk);
                echo[k] = 1'b1;
                repeat (cfg_w[k]) @(negedge clk);
                echo[k] = 1'b0;
            end
            2: begin
                repeat (100) @(negedge clk);
                echo[k] = 1'b0;
            end
            3: begin
                repeat (10) @(negedge clk);
                echo[k] = 1'b0;
                repeat (cfg_d[k]) @(negedge clk);
                echo[k] = 1'b1;
                repeat (cfg_w[k]) @(negedge clk);
                echo[k] = 1'b0;
            end
            default: ;
        endcase
    endtask

    // One complete sweep: start, serve each enabled sonar, check the results
    task automatic sweep(input logic [N_CH-1:0] en, input string tag, input bit poke);
        int              p0, t, last_fall;
        int              r0 [N_CH];
        bit              ok, first;
        logic [N_CH-1:0] oh;
        p0 = pronto_cnt;
        for (int k = 0; k < N_CH; k++) r0[k] = rise_cnt[k];
        habilita = en;
        @(negedge clk) medir = 1'b1;
        @(negedge clk) medir = 1'b0;
        @(negedge clk) habilita = ~en;   // must not affect this sweep
        first = 1'b1;
        last_fall = 0;
        for (int k = 0; k < N_CH; k++) begin
            if (en[k]) begin
                if (cfg_m[k] >= 2) echo[k] = 1'b1;
                ok = 1'b0;
                for (int n = 0; n < 5000; n++) begin
                    if (trigger_o != '0) begin ok = 1'b1; break; end
                    @(negedge clk);
                end
                chk({tag, "_trig_seen"}, 64'(ok), 64'd1);
                if (!ok) return;
                oh = '0;
                oh[k] = 1'b1;
                chk({tag, "_trig_onehot"}, 64'(trigger_o), 64'(oh));
                if (!first) chk({tag, "_gap"}, 64'((cyc - last_fall) >= GAP), 64'd1);
                t = 0;
                while (trigger_o == oh && t < 100) begin @(negedge clk); t++; end
                chk({tag, "_trig_width"}, 64'(t), 64'(TRIG));
                last_fall = cyc;
                first = 1'b0;
                if (poke && cfg_m[k] == 0) begin
                    medir = 1'b1;
                    @(negedge clk) medir = 1'b0;
                end
                drive_echo(k);
                model_update(k);
            end
        end
        ok = 1'b0;
        for (int n = 0; n < 5000; n++) begin
            @(negedge clk);
            if (pronto_cnt != p0) begin ok = 1'b1; break; end
        end
        chk({tag, "_pronto_seen"}, 64'(ok), 64'd1);
        repeat (20) @(negedge clk);
        chk({tag, "_pronto_once"}, 64'(pronto_cnt - p0), 64'd1);
        chk({tag, "_idle_after"}, 64'(ocupado_o), 64'd0);
        for (int k = 0; k < N_CH; k++) begin
            chk({tag, $sformatf("_dist%0d", k)}, 64'(distancia_o[k*DIST_W +: DIST_W]), 64'(m_dist[k]));
            chk({tag, $sformatf("_val%0d", k)}, 64'(valido_o[k]), 64'(m_val[k]));
            chk({tag, $sformatf("_fires%0d", k)}, 64'(rise_cnt[k] - r0[k]), 64'(en[k]));
        end
    endtask

    initial begin
        bit ok;
        int p0;
        int r0 [N_CH];
        rst_n = 1'b0; medir = 1'b0; continuo = 1'b0; habilita = '0; echo = '0;
        for (int k = 0; k < N_CH; k++) begin m_dist[k] = 0; m_val[k] = 1'b0; end

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_trigger", 64'(trigger_o), 64'd0);
        chk("rst_dist", 64'(distancia_o), 64'd0);
        chk("rst_valido", 64'(valido_o), 64'd0);
        chk("rst_pronto", 64'(pronto_o), 64'd0);
        chk("rst_ocupado", 64'(ocupado_o), 64'd0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // cm boundaries around 10 cm and a mid value
        cfg_rand();
        cfg_w[0] = 10 * CM - PRE - 1; cfg_w[1] = 10 * CM - PRE; cfg_w[2] = 5 * CM + 7;
        sweep(3'b111, "bound", 1'b0);

        // Random widths, all enabled
        for (int s = 0; s < 3; s++) begin
            cfg_rand();
            sweep(3'b111, $sformatf("rand%0d", s), 1'b0);
        end

        // Channel 1 masked; medir pokes mid-sweep must not start another sweep
        cfg_rand();
        sweep(3'b101, "mask101", 1'b1);

        // Silent channel 1 times out
        cfg_rand();
        cfg_m[1] = 1;
        sweep(3'b111, "timeout", 1'b0);

        // Stuck-high echoes: ch0 never rises, ch2 falls then gives a real echo
        cfg_rand();
        cfg_m[0] = 2; cfg_m[2] = 3;
        sweep(3'b101, "stuck", 1'b0);

        // Saturation edge: exactly full range is valid, one more cycle is not
        cfg_rand();
        cfg_w[0] = KSAT; cfg_w[1] = KSAT + 1; cfg_w[2] = KSAT + 25;
        sweep(3'b111, "sat", 1'b0);

        // No channel enabled: pronto two cycles after LOAD, no trigger
        for (int k = 0; k < N_CH; k++) r0[k] = rise_cnt[k];
        habilita = '0;
        @(negedge clk) medir = 1'b1;
        @(negedge clk) medir = 1'b0;
        chk("none_load_busy", 64'(ocupado_o), 64'd1);
        chk("none_load_pronto", 64'(pronto_o), 64'd0);
        @(negedge clk);
        chk("none_sel_pronto", 64'(pronto_o), 64'd0);
        @(negedge clk);
        chk("none_done_pronto", 64'(pronto_o), 64'd1);
        chk("none_done_busy", 64'(ocupado_o), 64'd0);
        @(negedge clk);
        chk("none_after_pronto", 64'(pronto_o), 64'd0);

        // Continuous mode, nothing enabled: a pronto every three cycles
        continuo = 1'b1;
        @(negedge clk) medir = 1'b1;
        @(negedge clk) medir = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("cont_pronto1", 64'(pronto_o), 64'd1);
        @(negedge clk);
        chk("cont_reload", 64'(pronto_o), 64'd0);
        chk("cont_reload_busy", 64'(ocupado_o), 64'd1);
        @(negedge clk);
        @(negedge clk);
        chk("cont_pronto2", 64'(pronto_o), 64'd1);
        continuo = 1'b0;
        @(negedge clk);
        chk("cont_stop", 64'(ocupado_o), 64'd0);
        for (int k = 0; k < N_CH; k++) chk($sformatf("none_fires%0d", k), 64'(rise_cnt[k] - r0[k]), 64'd0);

        // Asynchronous reset in the middle of a trigger pulse
        habilita = 3'b111;
        @(negedge clk) medir = 1'b1;
        @(negedge clk) medir = 1'b0;
        ok = 1'b0;
        for (int n = 0; n < 200; n++) begin
            @(negedge clk);
            if (trigger_o != '0) begin ok = 1'b1; break; end
        end
        chk("mid_trig_seen", 64'(ok), 64'd1);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_trigger", 64'(trigger_o), 64'd0);
        chk("mid_rst_dist", 64'(distancia_o), 64'd0);
        chk("mid_rst_valido", 64'(valido_o), 64'd0);
        chk("mid_rst_ocupado", 64'(ocupado_o), 64'd0);
        for (int k = 0; k < N_CH; k++) begin m_dist[k] = 0; m_val[k] = 1'b0; end
        @(negedge clk) rst_n = 1'b1;
        p0 = pronto_cnt;
        repeat (3) @(negedge clk);
        chk("post_rst_quiet", 64'(pronto_cnt - p0), 64'd0);

        // Recovery sweep on one channel
        cfg_rand();
        sweep(3'b010, "recover", 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule : tb_sonar_array

`default_nettype wire
